// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  localparam int MEM_LAT_DEFAULT = 4;

endpackage

// File: rtl/arb_lat_counter.sv
// 4-bit latency down-counter: loads on grant, counts down, flags zero.
module arb_lat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       zero
);

  logic [3:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count = count_q;
    zero  = (count_q == '0);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction- and data-cache misses onto one memory port,
// alternating grants on ties and holding one access in flight at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ack,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_stall,
  output logic        busy
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  arb_state_t  state_d, state_q;
  grant_t      last_d, last_q;
  logic [15:0] addr_d, addr_q;
  logic [15:0] wdata_d, wdata_q;
  logic        wr_d, wr_q;

  logic        cnt_load, cnt_dec, cnt_zero;
  logic [3:0]  cnt;
  logic        grant_i, grant_d;

  arb_lat_counter u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LAT),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // On a tie, the requester not granted last time wins.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if ((state_q == IDLE) && !mem_stall) begin
      if (i_req && d_req) begin
        grant_d = (last_q == GNT_I);
        grant_i = (last_q == GNT_D);
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = D_XFER;
          last_d   = GNT_D;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          wr_d     = d_wr;
          cnt_load = 1'b1;
        end else if (grant_i) begin
          state_d  = I_XFER;
          last_d   = GNT_I;
          addr_d   = i_addr;
          wdata_d  = '0;
          wr_d     = 1'b0;
          cnt_load = 1'b1;
        end
      end
      I_XFER, D_XFER: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GNT_I;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  // The counter still holds its load value only in the first transfer cycle.
  always_comb begin
    busy      = (state_q != IDLE);
    mem_en    = busy && (cnt == LAT);
    mem_wr    = (state_q == D_XFER) && wr_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_ack     = (state_q == I_XFER) && cnt_zero;
    d_ack     = (state_q == D_XFER) && cnt_zero;
    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with MEM_LAT = 4.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr, mem_stall;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_ack, d_ack, mem_en, mem_wr, busy;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_stall (mem_stall),
    .busy      (busy)
  );

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        chg_addr;
    logic        drop_req;
    logic [15:0] exp_addr;
    logic        exp_wr;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Request placed at a negedge; k counts cycles after the granting edge.
  task automatic run_vec(input vec_t v);
    int en_cnt = 0, first_en = 0, ack_cnt = 0, ack_cyc = 0, wrong = 0;
    @(negedge clk);
    mem_rdata = v.rdata;
    if (v.is_d) begin
      d_req = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        if (first_en == 0) first_en = k;
        chk("mem_wr", {31'b0, mem_wr}, {31'b0, v.exp_wr});
        if (v.exp_wr) chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, v.exp_wdata});
      end
      if (busy) chk("xfer_addr", {16'b0, mem_addr}, {16'b0, v.exp_addr});
      if (v.is_d ? i_ack : d_ack) wrong++;
      if (v.is_d ? d_ack : i_ack) begin
        ack_cnt++;
        ack_cyc = k;
        if (!v.wr) chk("rdata", {16'b0, v.is_d ? d_rdata : i_rdata}, {16'b0, v.rdata});
        i_req = 1'b0;
        d_req = 1'b0;
      end
      if (k == 2) begin
        if (v.chg_addr) d_addr = 16'h5678;
        if (v.drop_req) begin i_req = 1'b0; d_req = 1'b0; end
      end
    end
    chk("mem_en_count", en_cnt, 1);
    chk("mem_en_cycle", first_en, 1);
    chk("ack_count", ack_cnt, 1);
    chk("ack_cycle", ack_cyc, 5);
    chk("wrong_ack", wrong, 0);
    chk("busy_after", {31'b0, busy}, 0);
  endtask

  initial begin
    int got, overlap, b2b, ng;
    logic prev_en;
    logic [15:0] gnt[4];

    vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 16'h0040, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 16'h1234, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b1, 16'hA5A5};
    vecs[2] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h1357, 1'b0, 1'b0, 16'h00FF, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 16'h1234, 16'h0F0F, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b1, 16'h0F0F};
    vecs[4] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h2468, 1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0000};

    rst = 1'b1; i_req = 0; d_req = 0; d_wr = 0; mem_stall = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_mem_en", {31'b0, mem_en}, 0);
    chk("rst_acks", {30'b0, i_ack, d_ack}, 0);
    chk("rst_addr", {16'b0, mem_addr}, 0);
    chk("rst_wdata", {16'b0, mem_wdata}, 0);
    rst = 1'b0;

    for (int n = 0; n < 5; n++) begin
      run_vec(vecs[n]);
    end

    // Stall holds off the grant until the first stall-free edge.
    @(negedge clk);
    mem_stall = 1'b1; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0BAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_no_en", {30'b0, mem_en, busy}, 0);
    end
    mem_stall = 1'b0;
    @(negedge clk);
    chk("stall_release_en", {31'b0, mem_en}, 1);
    mem_stall = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      @(negedge clk);
      if (d_ack) begin got = 1; d_req = 1'b0; end
    end
    chk("stall_ack", got, 1);
    mem_stall = 1'b0;

    // Both requests held from reset release: grants alternate D, I, D, I.
    @(negedge clk);
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
    i_addr = 16'h1111; d_addr = 16'h2222;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    overlap = 0; b2b = 0; ng = 0; prev_en = 1'b0;
    for (int k = 0; k < 60 && ng < 4; k++) begin
      @(negedge clk);
      if (i_ack && d_ack) overlap++;
      if (mem_en && prev_en) b2b++;
      if (mem_en) begin gnt[ng] = mem_addr; ng++; end
      prev_en = mem_en;
    end
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (i_ack && d_ack) overlap++;
    end
    chk("alt_grant_count", ng, 4);
    chk("alt_grant0", {16'b0, gnt[0]}, 32'h2222);
    chk("alt_grant1", {16'b0, gnt[1]}, 32'h1111);
    chk("alt_grant2", {16'b0, gnt[2]}, 32'h2222);
    chk("alt_grant3", {16'b0, gnt[3]}, 32'h1111);
    chk("ack_overlap", overlap, 0);
    chk("back_to_back_en", b2b, 0);

    // Reset two cycles into a data transfer drops it silently.
    @(negedge clk);
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h3333; d_wdata = 16'h4444;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", {31'b0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_ack", {31'b0, d_ack}, 0);
    chk("midrst_addr", {16'b0, mem_addr}, 0);
    rst = 1'b0; d_req = 1'b0;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (d_ack) got++;
    end
    chk("midrst_no_ack", got, 0);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
